// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// and the opcode legality check.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_W = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Opcodes 110 and 111 have no ALU function behind them
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU shared by both requesters.
module alu_core
    import alu_share_arbiter_pkg::*;
(
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [ALU_W-1:0] C
);

    logic [4:0] shamt;

    assign shamt = B[4:0];

    // Select the operation; illegal opcodes produce zero
    always_comb begin
        C = '0;
        case (ALUOp)
            ALU_ADD: C = A + B;
            ALU_SUB: C = A - B;
            ALU_AND: C = A & B;
            ALU_OR:  C = A | B;
            ALU_SRL: C = A >> shamt;
            ALU_SRA: C = $signed(A) >>> shamt;
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// One operation outstanding at a time: IDLE (grant) -> EXEC -> RESP.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic [2:0]       in0_op,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_c,
    output logic             out0_err,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    input  logic [2:0]       in1_op,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_c,
    output logic             out1_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [2:0]       lat_op;

    logic             gnt;
    logic             any_valid;
    logic             hs;
    logic             resp_done;
    logic [WIDTH-1:0] alu_c;
    logic             op_ok;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        any_valid = in0_valid | in1_valid;
        gnt       = 1'b0;
        if (in0_valid && in1_valid) begin
            gnt = ~last_grant;
        end else if (in1_valid) begin
            gnt = 1'b1;
        end
    end

    // Ready is combinational and only offered while IDLE and out of reset
    assign in0_ready = rst_n && (state == S_IDLE) && any_valid && !gnt;
    assign in1_ready = rst_n && (state == S_IDLE) && any_valid &&  gnt;
    assign hs        = in0_ready | in1_ready;
    assign resp_done = owner ? out1_ready : out0_ready;
    assign busy      = (state != S_IDLE);
    assign op_ok     = is_legal_op(lat_op);

    alu_core u_alu (
        .A     (lat_a),
        .B     (lat_b),
        .ALUOp (lat_op),
        .C     (alu_c)
    );

    // Control FSM with operand latch and per-requester result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= ALU_ADD;
            out0_valid <= 1'b0;
            out0_c     <= '0;
            out0_err   <= 1'b0;
            out1_valid <= 1'b0;
            out1_c     <= '0;
            out1_err   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        lat_a      <= gnt ? in1_a  : in0_a;
                        lat_b      <= gnt ? in1_b  : in0_b;
                        lat_op     <= gnt ? in1_op : in0_op;
                        owner      <= gnt;
                        last_grant <= gnt;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Only the owner's result registers move; the other side holds
                    if (owner) begin
                        out1_c     <= op_ok ? alu_c : '0;
                        out1_err   <= ~op_ok;
                        out1_valid <= 1'b1;
                    end else begin
                        out0_c     <= op_ok ? alu_c : '0;
                        out0_err   <= ~op_ok;
                        out0_valid <= 1'b1;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_done) begin
                        out0_valid <= 1'b0;
                        out1_valid <= 1'b0;
                        op_count   <= op_count + CNT_W'(1);
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter with a behavioural model.
module tb_alu_share_arbiter;

    localparam int unsigned TB_CNT_W = 4;

    logic                clk;
    logic                rst_n;
    logic                in0_valid, in1_valid;
    logic                in0_ready, in1_ready;
    logic [31:0]         in0_a, in0_b, in1_a, in1_b;
    logic [2:0]          in0_op, in1_op;
    logic                out0_valid, out1_valid;
    logic                out0_ready, out1_ready;
    logic [31:0]         out0_c, out1_c;
    logic                out0_err, out1_err;
    logic                busy;
    logic [TB_CNT_W-1:0] op_count;

    int checks;
    int errors;

    // Model state: who was served last, completed count, last result per side
    int          m_last;
    int          m_count;
    logic [31:0] m_c [2];
    logic        m_err [2];

    alu_share_arbiter #(.WIDTH(32), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in0_a      (in0_a),
        .in0_b      (in0_b),
        .in0_op     (in0_op),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_c     (out0_c),
        .out0_err   (out0_err),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .in1_a      (in1_a),
        .in1_b      (in1_b),
        .in1_op     (in1_op),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_c     (out1_c),
        .out1_err   (out1_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {err, result} from the opcode table
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        int unsigned s;
        logic [31:0] r;
        s = b % 32;
        r = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a >> s;
            3'd5: begin
                r = a >> s;
                if (a[31]) for (int i = 0; i < int'(s); i++) r[31-i] = 1'b1;
            end
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic model_reset();
        m_last   = 1;
        m_count  = 0;
        m_c[0]   = '0;
        m_c[1]   = '0;
        m_err[0] = 1'b0;
        m_err[1] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in0_ready"}, in0_ready, 0);
        chk({tag, "_in1_ready"}, in1_ready, 0);
        chk({tag, "_out0_valid"}, out0_valid, 0);
        chk({tag, "_out1_valid"}, out1_valid, 0);
        chk({tag, "_out0_c"}, out0_c, 0);
        chk({tag, "_out1_c"}, out1_c, 0);
        chk({tag, "_out0_err"}, out0_err, 0);
        chk({tag, "_out1_err"}, out1_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_op_count"}, 32'(op_count), 0);
    endtask

    task automatic check_resp(input int w, input logic [31:0] ec, input logic ee);
        chk("resp_out0_valid", out0_valid, (w == 0));
        chk("resp_out1_valid", out1_valid, (w == 1));
        chk("resp_out0_c", out0_c, (w == 0) ? ec : m_c[0]);
        chk("resp_out1_c", out1_c, (w == 1) ? ec : m_c[1]);
        chk("resp_out0_err", out0_err, (w == 0) ? ee : m_err[0]);
        chk("resp_out1_err", out1_err, (w == 1) ? ee : m_err[1]);
        chk("resp_in0_ready", in0_ready, 0);
        chk("resp_in1_ready", in1_ready, 0);
        chk("resp_busy", busy, 1);
    endtask

    // One complete transaction starting in IDLE; stall = cycles of response backpressure
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                           input int unsigned stall);
        int w;
        logic [32:0] r;
        in0_valid = v0; in0_a = a0; in0_b = b0; in0_op = op0;
        in1_valid = v1; in1_a = a1; in1_b = b1; in1_op = op1;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        if (v0 && v1) w = (m_last == 0) ? 1 : 0;
        else          w = v0 ? 0 : 1;
        r = (w == 0) ? ref_alu(a0, b0, op0) : ref_alu(a1, b1, op1);
        #1;
        chk("grant_in0_ready", in0_ready, (w == 0));
        chk("grant_in1_ready", in1_ready, (w == 1));
        chk("grant_busy", busy, 0);
        @(negedge clk);
        // Winner drops its request and scrambles operands; only the handshake values count
        if (w == 0) begin
            in0_valid = 1'b0; in0_a = $urandom; in0_b = $urandom; in0_op = 3'($urandom);
        end else begin
            in1_valid = 1'b0; in1_a = $urandom; in1_b = $urandom; in1_op = 3'($urandom);
        end
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_in0_ready", in0_ready, 0);
        chk("exec_in1_ready", in1_ready, 0);
        chk("exec_out0_valid", out0_valid, 0);
        chk("exec_out1_valid", out1_valid, 0);
        @(negedge clk);
        for (int unsigned i = 0; i < stall; i++) begin
            check_resp(w, r[31:0], r[32]);
            @(negedge clk);
        end
        check_resp(w, r[31:0], r[32]);
        if (w == 0) out0_ready = 1'b1; else out1_ready = 1'b1;
        @(negedge clk);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        m_count  = (m_count + 1) % (1 << TB_CNT_W);
        m_c[w]   = r[31:0];
        m_err[w] = r[32];
        m_last   = w;
        chk("done_op_count", 32'(op_count), 32'(m_count));
        chk("done_out0_valid", out0_valid, 0);
        chk("done_out1_valid", out1_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        int sel;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 1'b0;
        in0_valid = 1'b0; in0_a = '0; in0_b = '0; in0_op = '0;
        in1_valid = 1'b0; in1_a = '0; in1_b = '0; in1_op = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single add on requester 0
        run_txn(1, 0, 32'd5, 32'd7, 3'b000, '0, '0, '0, 0);
        chk("add_result", out0_c, 32'd12);

        // Shifts by B[4:0] = 1 with B = 33
        run_txn(1, 0, 32'h8000_0000, 32'd33, 3'b101, '0, '0, '0, 0);
        chk("sra_result", out0_c, 32'hC000_0000);
        run_txn(1, 0, 32'h8000_0000, 32'd33, 3'b100, '0, '0, '0, 0);
        chk("srl_result", out0_c, 32'h4000_0000);

        // Illegal opcodes on both sides
        run_txn(0, 1, '0, '0, '0, 32'hDEAD_BEEF, 32'h1234_5678, 3'b111, 0);
        chk("illegal_c", out1_c, 32'h0);
        chk("illegal_err", out1_err, 1);
        run_txn(1, 0, 32'hFFFF_FFFF, 32'h1, 3'b110, '0, '0, '0, 1);

        // Backpressure: requester 1 wins and stalls while requester 0 waits
        run_txn(1, 1, 32'd100, 32'd1, 3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 10);
        run_txn(1, 0, 32'd100, 32'd1, 3'b001, '0, '0, '0, 0);

        // Reset asserted during EXEC discards the operation
        in0_valid = 1'b1; in0_a = 32'd9; in0_b = 32'd9; in0_op = 3'b000;
        #1;
        chk("rstmid_grant", in0_ready, 1);
        @(negedge clk);
        in0_valid = 1'b0;
        #1;
        chk("rstmid_busy_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("post_rst_out0_valid", out0_valid, 0);
        chk("post_rst_busy", busy, 0);
        @(negedge clk);
        chk("post_rst_out0_valid2", out0_valid, 0);

        // Continuous contention after reset: strict 0,1,0,1 alternation
        for (int k = 0; k < 4; k++) begin
            run_txn(1, 1, $urandom, $urandom, 3'($urandom_range(0, 5)),
                    $urandom, $urandom, 3'($urandom_range(0, 5)), 0);
            chk("alt_order", 32'(m_last), 32'(k % 2));
        end

        // Random traffic; count passes the 4-bit wrap
        for (int k = 0; k < 20; k++) begin
            sel = $urandom_range(1, 3);
            run_txn(sel[0], sel[1], $urandom, $urandom, 3'($urandom_range(0, 7)),
                    $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 32-bit ALU datapath (ops add/sub/and/or/srl/sra) between two independent requesters. Each requester has a valid/ready request channel and a valid/ready response channel. Grants use round-robin arbitration. Operands are latched, the ALU result is registered, and the result is returned only to the requester that issued the operation. The block sits between instruction-issue logic (e.g. a main pipeline and a multi-cycle helper unit) and the ALU.

Parameters:
- WIDTH, 32, operand/result width (ALU is fixed at 32; no other value is supported).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in0_valid  in  1  requester 0 has an operation
- in0_ready  out  1  request 0 accepted this cycle when in0_valid is also high
- in0_a  in  32  operand A
- in0_b  in  32  operand B
- in0_op  in  3  ALU opcode
- out0_valid  out  1  result for requester 0 is available
- out0_ready  in  1  requester 0 consumes the result
- out0_c  out  32  result
- out0_err  out  1  opcode was illegal; out0_c is 0
- in1_* / out1_*  same as requester 0, for requester 1
- busy  out  1  FSM not in IDLE
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state clears immediately on assertion, regardless of FSM state.
- Reset values: all *_ready, out*_valid, out*_err and busy are 0; out*_c is 0; op_count is 0; last_grant is 1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP. Only one operation is outstanding at a time.
- IDLE:
  - grant = the only valid requester; if both are valid, the one != last_grant.
  - inX_ready is driven combinationally, high only for the granted requester, and only in IDLE.
  - On handshake: latch a, b, op and the grant id; update last_grant; go to EXEC.
  - No valid requester: stay in IDLE.
- EXEC, one cycle:
  - The ALU computes from the latched operands.
  - Result, err and owner are registered; go to RESP.
- RESP:
  - outX_valid is high for the owner only. outX_c and outX_err stay stable until the handshake.
  - The non-owner's out_valid is 0 and its out_c holds its previous value.
  - On outX_ready: increment op_count, go to IDLE.
  - Without ready: hold indefinitely (backpressure). New requests are not accepted.
- Latency: request handshake in cycle N gives out_valid high in cycle N+2. Minimum issue interval per operation is 3 cycles.
- Opcodes:
  - 000: A+B (carry dropped, mod 2^32).
  - 001: A-B (mod 2^32).
  - 010: A&B.
  - 011: A|B.
  - 100: logical A>>B[4:0].
  - 101: arithmetic A>>>B[4:0].
  - Shift amount is B[4:0]; B[31:5] is ignored.
  - 110 and 111 are illegal: result 0, err 1, still a normal response that counts in op_count.
- Simultaneous requests: the loser's in_ready stays 0. It keeps its valid and wins the next IDLE grant, so a continuously requesting pair alternates strictly.
- Input changes: inX_* changing while ready is 0 has no effect. Operands are sampled only at the handshake.
- Reset mid-operation: the pending operation is discarded and no response is produced. op_count is not incremented.
- op_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package holds:
  - opcode constants ALU_ADD=3'b000, ALU_SUB, ALU_AND, ALU_OR, ALU_SRL, ALU_SRA.
  - FSM state encoding S_IDLE/S_EXEC/S_RESP.
  - an is_legal_op function.
- One sub-module: alu_core, the purely combinational 32-bit ALU with ports A, B, ALUOp, C. It is instantiated once, fed from the latched operand registers.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single add: in0 a=5, b=7, op=000, handshake at cycle N. Expect out0_valid at N+2, out0_c=12, err=0, op_count=1. Requester 1 outputs stay idle.
- Shifts: op=101, a=0x80000000, b=33. Expect out_c=0xC0000000 (shift by 1). Then op=100, same inputs: expect 0x40000000.
- Arbitration: both requesters valid continuously after reset. Expect grants in the order 0,1,0,1. Expect in1_ready=0 on cycles when 0 is granted, and results routed to the correct requester each time.
- Backpressure: hold out1_ready=0 for 10 cycles with in0_valid=1. Expect out1_valid and out1_c stable, in0_ready=0 throughout, and the in0 grant in the cycle after the out1 handshake.
- Illegal op and wrap: op=111 gives out_c=0 and err=1. Preload the count with 0xFFFF completions (or force CNT_W=2 in a test build). The next completion gives op_count=0.
- Reset mid-op: assert rst_n=0 during EXEC. Expect all outputs 0 immediately and asynchronously, and after release no stale out_valid.
